// File: rtl/avmm_bar_arbiter.sv
// Two-master Avalon-MM arbiter sharing one burst-capable slave (PCIe BAR0 path vs. local master).
// Optional read-response watchdog is built when AVMM_ARB_TIMEOUT_EN is defined.
module avmm_bar_arbiter #(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic        i_Clk,
    input  logic        i_Reset,

    input  logic [31:0] i_M0Address,
    input  logic        i_M0Read,
    input  logic        i_M0Write,
    input  logic [31:0] i_M0WriteData,
    input  logic [3:0]  i_M0ByteEnable,
    input  logic [6:0]  i_M0BurstCount,
    output logic        o_M0WaitRequest,
    output logic        o_M0ReadDataValid,
    output logic [31:0] o_M0ReadData,

    input  logic [31:0] i_M1Address,
    input  logic        i_M1Read,
    input  logic        i_M1Write,
    input  logic [31:0] i_M1WriteData,
    input  logic [3:0]  i_M1ByteEnable,
    input  logic [6:0]  i_M1BurstCount,
    output logic        o_M1WaitRequest,
    output logic        o_M1ReadDataValid,
    output logic [31:0] o_M1ReadData,

    output logic [31:0] o_SAddress,
    output logic        o_SRead,
    output logic        o_SWrite,
    output logic [31:0] o_SWriteData,
    output logic [3:0]  o_SByteEnable,
    output logic [6:0]  o_SBurstCount,
    input  logic        i_SWaitRequest,
    input  logic        i_SReadDataValid,
    input  logic [31:0] i_SReadData,

    output logic [1:0]  o_Grant,
    output logic        o_TimeoutErr
);

    typedef enum logic [1:0] {IDLE, WRITE, READ_CMD, READ_DATA} state_t;

    state_t      r_state;
    state_t      w_nextState;
    state_t      w_state;
    logic        r_owner;
    logic        r_lastGrant;
    logic [6:0]  r_burstLen;
    logic [6:0]  r_beatCount;

    logic        w_req0;
    logic        w_req1;
    logic        w_winner;
    logic        w_winnerWrite;
    logic [6:0]  w_winnerBurst;
    logic [6:0]  w_winnerLen;
    logic        w_ownRead;
    logic        w_ownWrite;
    logic        w_ownWait;
    logic        w_granted;
    logic        w_writeBeat;
    logic        w_readCmdAccept;
    logic        w_readBeat;
    logic        w_lastBeat;
    logic        w_timeout;

    assign w_req0 = i_M0Read | i_M0Write;
    assign w_req1 = i_M1Read | i_M1Write;

    // On a tie the master not granted last wins unless M0 is pinned as priority
    always_comb begin
        w_winner = 1'b0;
        if (w_req0 && w_req1)
            w_winner = FIXED_PRIORITY ? 1'b0 : ~r_lastGrant;
        else if (w_req1)
            w_winner = 1'b1;
    end

    assign w_winnerWrite = w_winner ? i_M1Write : i_M0Write;
    assign w_winnerBurst = w_winner ? i_M1BurstCount : i_M0BurstCount;
    assign w_winnerLen   = (w_winnerBurst == 7'd0) ? 7'd1 : w_winnerBurst;

    assign w_ownRead  = r_owner ? i_M1Read  : i_M0Read;
    assign w_ownWrite = r_owner ? i_M1Write : i_M0Write;

    assign w_writeBeat     = (r_state == WRITE) && w_ownWrite && !i_SWaitRequest;
    assign w_readCmdAccept = (r_state == READ_CMD) && w_ownRead && !i_SWaitRequest;
    assign w_readBeat      = (r_state == READ_DATA) && i_SReadDataValid;
    assign w_lastBeat      = (r_beatCount + 7'd1) == r_burstLen;

`ifdef AVMM_ARB_TIMEOUT_EN
    logic [7:0] r_timeoutCnt;
    logic       r_timeoutErr;

    // Watchdog trips on the cycle the idle count would reach 255
    assign w_timeout = (r_state == READ_DATA) && !i_SReadDataValid && (r_timeoutCnt == 8'd254);

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_timeoutCnt <= 8'd0;
            r_timeoutErr <= 1'b0;
        end else begin
            if ((r_state != READ_DATA) || i_SReadDataValid)
                r_timeoutCnt <= 8'd0;
            else
                r_timeoutCnt <= r_timeoutCnt + 8'd1;
            if (w_timeout)
                r_timeoutErr <= 1'b1;
        end
    end

    assign o_TimeoutErr = r_timeoutErr;
`else
    assign w_timeout    = 1'b0;
    assign o_TimeoutErr = 1'b0;
`endif

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_req0 || w_req1)
                    w_nextState = w_winnerWrite ? WRITE : READ_CMD;
            end
            WRITE: begin
                if (w_writeBeat && w_lastBeat)
                    w_nextState = IDLE;
            end
            READ_CMD: begin
                if (w_readCmdAccept)
                    w_nextState = READ_DATA;
            end
            READ_DATA: begin
                if ((w_readBeat && w_lastBeat) || w_timeout)
                    w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state     <= IDLE;
            r_owner     <= 1'b0;
            r_lastGrant <= 1'b1;
            r_burstLen  <= 7'd0;
            r_beatCount <= 7'd0;
        end else begin
            r_state <= w_nextState;
            if ((r_state == IDLE) && (w_req0 || w_req1)) begin
                r_owner     <= w_winner;
                r_lastGrant <= w_winner;
                r_burstLen  <= w_winnerLen;
                r_beatCount <= 7'd0;
            end else if (w_writeBeat || w_readBeat) begin
                r_beatCount <= r_beatCount + 7'd1;
            end
        end
    end

    // Outputs decode as idle while reset is held so an abort takes effect at once
    assign w_state   = i_Reset ? IDLE : r_state;
    assign w_granted = (w_state != IDLE);
    assign w_ownWait = ((w_state == WRITE) || (w_state == READ_CMD)) ? i_SWaitRequest : 1'b1;

    assign o_Grant = w_granted ? (r_owner ? 2'b10 : 2'b01) : 2'b00;

    assign o_SAddress    = r_owner ? i_M1Address    : i_M0Address;
    assign o_SWriteData  = r_owner ? i_M1WriteData  : i_M0WriteData;
    assign o_SByteEnable = r_owner ? i_M1ByteEnable : i_M0ByteEnable;
    assign o_SBurstCount = r_owner ? i_M1BurstCount : i_M0BurstCount;
    assign o_SWrite      = (w_state == WRITE) && w_ownWrite;
    assign o_SRead       = (w_state == READ_CMD) && w_ownRead;

    assign o_M0WaitRequest = (w_granted && !r_owner) ? w_ownWait : 1'b1;
    assign o_M1WaitRequest = (w_granted &&  r_owner) ? w_ownWait : 1'b1;

    assign o_M0ReadDataValid = (w_state == READ_DATA) && !r_owner && i_SReadDataValid;
    assign o_M1ReadDataValid = (w_state == READ_DATA) &&  r_owner && i_SReadDataValid;
    assign o_M0ReadData      = i_SReadData;
    assign o_M1ReadData      = i_SReadData;

endmodule

// File: tb/tb_avmm_bar_arbiter.sv
// Directed bench for avmm_bar_arbiter: arbitration order, write/read bursts, stalls, reset abort.
// The watchdog scenario runs only when AVMM_ARB_TIMEOUT_EN is defined for the build.
module tb_avmm_bar_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] m0Address, m1Address, m0WriteData, m1WriteData;
    logic        m0Read, m0Write, m1Read, m1Write;
    logic [3:0]  m0ByteEnable, m1ByteEnable;
    logic [6:0]  m0BurstCount, m1BurstCount;
    logic        m0WaitRequest, m1WaitRequest, m0ReadDataValid, m1ReadDataValid;
    logic [31:0] m0ReadData, m1ReadData;
    logic [31:0] sAddress, sWriteData, sReadData;
    logic        sRead, sWrite, sWaitRequest, sReadDataValid;
    logic [3:0]  sByteEnable;
    logic [6:0]  sBurstCount;
    logic [1:0]  grant;
    logic        timeoutErr;

    int totalCount = 0;
    int badCount   = 0;

    avmm_bar_arbiter #(.FIXED_PRIORITY(1'b0)) dut (
        .i_Clk(clk), .i_Reset(reset),
        .i_M0Address(m0Address), .i_M0Read(m0Read), .i_M0Write(m0Write),
        .i_M0WriteData(m0WriteData), .i_M0ByteEnable(m0ByteEnable), .i_M0BurstCount(m0BurstCount),
        .o_M0WaitRequest(m0WaitRequest), .o_M0ReadDataValid(m0ReadDataValid), .o_M0ReadData(m0ReadData),
        .i_M1Address(m1Address), .i_M1Read(m1Read), .i_M1Write(m1Write),
        .i_M1WriteData(m1WriteData), .i_M1ByteEnable(m1ByteEnable), .i_M1BurstCount(m1BurstCount),
        .o_M1WaitRequest(m1WaitRequest), .o_M1ReadDataValid(m1ReadDataValid), .o_M1ReadData(m1ReadData),
        .o_SAddress(sAddress), .o_SRead(sRead), .o_SWrite(sWrite), .o_SWriteData(sWriteData),
        .o_SByteEnable(sByteEnable), .o_SBurstCount(sBurstCount),
        .i_SWaitRequest(sWaitRequest), .i_SReadDataValid(sReadDataValid), .i_SReadData(sReadData),
        .o_Grant(grant), .o_TimeoutErr(timeoutErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        if (observed !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkCtl(input string tag, input logic [1:0] g, input logic w0, input logic w1,
                            input logic sr, input logic sw);
        checkOutput({tag, ".grant"}, 32'(grant), 32'(g));
        checkOutput({tag, ".m0Wait"}, 32'(m0WaitRequest), 32'(w0));
        checkOutput({tag, ".m1Wait"}, 32'(m1WaitRequest), 32'(w1));
        checkOutput({tag, ".sRead"}, 32'(sRead), 32'(sr));
        checkOutput({tag, ".sWrite"}, 32'(sWrite), 32'(sw));
    endtask

    task automatic checkRdv(input string tag, input logic v0, input logic v1);
        checkOutput({tag, ".m0Rdv"}, 32'(m0ReadDataValid), 32'(v0));
        checkOutput({tag, ".m1Rdv"}, 32'(m1ReadDataValid), 32'(v1));
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic m0r, input logic m0w, input logic m1r, input logic m1w,
                                 input logic sWait, input logic sValid, input logic [31:0] sData);
        m0Read         = m0r;
        m0Write        = m0w;
        m1Read         = m1r;
        m1Write        = m1w;
        sWaitRequest   = sWait;
        sReadDataValid = sValid;
        sReadData      = sData;
        #1;
    endtask

    logic        rdValid [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] rdData  [5] = '{32'hA5A5A5A5, 32'h0, 32'h1, 32'h0, 32'h2};

    initial begin
        reset        = 1'b1;
        m0Address    = 32'h200;  m1Address    = 32'h300;
        m0WriteData  = 32'h0;    m1WriteData  = 32'h0;
        m0ByteEnable = 4'hF;     m1ByteEnable = 4'hF;
        m0BurstCount = 7'd1;     m1BurstCount = 7'd1;
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);

        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
        checkCtl("reset", 2'b00, 1, 1, 0, 0);
        checkRdv("reset", 0, 0);
        checkOutput("reset.err", 32'(timeoutErr), 32'h0);
        nextCycle();
        reset = 1'b0;

        // Simultaneous reads, last grant M1 after reset: M0 first then M1
        applyStimulus(1, 0, 1, 0, 0, 0, 32'h0);
        checkCtl("rr.c0", 2'b00, 1, 1, 0, 0);
        nextCycle();
        applyStimulus(1, 0, 1, 0, 0, 0, 32'h0);
        checkCtl("rr.c1", 2'b01, 0, 1, 1, 0);
        checkOutput("rr.c1.addr", sAddress, 32'h200);
        nextCycle();
        applyStimulus(0, 0, 1, 0, 0, 1, 32'h11111111);
        checkCtl("rr.c2", 2'b01, 1, 1, 0, 0);
        checkRdv("rr.c2", 1, 0);
        checkOutput("rr.c2.data", m0ReadData, 32'h11111111);
        nextCycle();
        applyStimulus(0, 0, 1, 0, 0, 0, 32'h0);
        checkCtl("rr.c3", 2'b00, 1, 1, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 1, 0, 0, 0, 32'h0);
        checkCtl("rr.c4", 2'b10, 1, 0, 1, 0);
        checkOutput("rr.c4.addr", sAddress, 32'h300);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h22222222);
        checkCtl("rr.c5", 2'b10, 1, 1, 0, 0);
        checkRdv("rr.c5", 0, 1);
        checkOutput("rr.c5.data", m1ReadData, 32'h22222222);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
        checkCtl("rr.c6", 2'b00, 1, 1, 0, 0);

        // M0 write burst of 4 with a ready slave
        m0Address = 32'h100; m0BurstCount = 7'd4; m0WriteData = 32'hCAFE0000; m0ByteEnable = 4'h3;
        nextCycle();
        applyStimulus(0, 1, 0, 0, 0, 0, 32'h0);
        checkCtl("wr.c0", 2'b00, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            applyStimulus(0, 1, 0, 0, 0, 0, 32'h0);
            checkCtl("wr.beat", 2'b01, 0, 1, 0, 1);
            checkOutput("wr.addr", sAddress, 32'h100);
            checkOutput("wr.burst", 32'(sBurstCount), 32'd4);
            checkOutput("wr.data", sWriteData, 32'hCAFE0000);
            checkOutput("wr.be", 32'(sByteEnable), 32'h3);
        end
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
        checkCtl("wr.done", 2'b00, 1, 1, 0, 0);

        // Tie with last grant M0: M1 wins; M0 burst 0 behaves as a single beat
        m0BurstCount = 7'd0; m1Address = 32'h500; m1BurstCount = 7'd1;
        nextCycle();
        applyStimulus(0, 1, 0, 1, 0, 0, 32'h0);
        checkCtl("tie.c0", 2'b00, 1, 1, 0, 0);
        nextCycle();
        applyStimulus(0, 1, 0, 1, 0, 0, 32'h0);
        checkCtl("tie.c1", 2'b10, 1, 0, 0, 1);
        checkOutput("tie.c1.addr", sAddress, 32'h500);
        nextCycle();
        applyStimulus(0, 1, 0, 0, 0, 0, 32'h0);
        checkCtl("tie.c2", 2'b00, 1, 1, 0, 0);
        nextCycle();
        applyStimulus(0, 1, 0, 0, 0, 0, 32'h0);
        checkCtl("tie.c3", 2'b01, 0, 1, 0, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
        checkCtl("tie.c4", 2'b00, 1, 1, 0, 0);

        // Slave stalls an M0 write for 5 cycles; beats must not count while stalled
        m0Address = 32'h180; m0BurstCount = 7'd2;
        nextCycle();
        applyStimulus(0, 1, 0, 0, 1, 0, 32'h0);
        checkCtl("stall.c0", 2'b00, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            applyStimulus(0, 1, 0, 0, 1, 0, 32'h0);
            checkCtl("stall.hold", 2'b01, 1, 1, 0, 1);
        end
        nextCycle();
        applyStimulus(0, 1, 0, 0, 0, 0, 32'h0);
        checkCtl("stall.b1", 2'b01, 0, 1, 0, 1);
        nextCycle();
        applyStimulus(0, 1, 0, 0, 0, 0, 32'h0);
        checkCtl("stall.b2", 2'b01, 0, 1, 0, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
        checkCtl("stall.done", 2'b00, 1, 1, 0, 0);

        // M1 read burst of 3 with gaps in the response stream
        m1Address = 32'h400; m1BurstCount = 7'd3;
        nextCycle();
        applyStimulus(0, 0, 1, 0, 0, 0, 32'h0);
        checkCtl("rd3.c0", 2'b00, 1, 1, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 1, 0, 0, 0, 32'h0);
        checkCtl("rd3.cmd", 2'b10, 1, 0, 1, 0);
        checkOutput("rd3.burst", 32'(sBurstCount), 32'd3);
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            applyStimulus(0, 0, 0, 0, 0, rdValid[i], rdData[i]);
            checkCtl("rd3.data", 2'b10, 1, 1, 0, 0);
            checkRdv("rd3.data", 0, rdValid[i]);
            checkOutput("rd3.value", m1ReadData, rdData[i]);
        end
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
        checkCtl("rd3.done", 2'b00, 1, 1, 0, 0);

        // Reset after the first of four read beats; later beats must be dropped
        m0Address = 32'h600; m0BurstCount = 7'd4;
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
        checkCtl("rab.cmd", 2'b01, 0, 1, 1, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 32'hBEEF0001);
        checkCtl("rab.beat1", 2'b01, 1, 1, 0, 0);
        checkRdv("rab.beat1", 1, 0);
        nextCycle();
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 1, 32'hBEEF0002);
        checkCtl("rab.inreset", 2'b00, 1, 1, 0, 0);
        checkRdv("rab.inreset", 0, 0);
        nextCycle();
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 1, 32'hBEEF0003);
        checkCtl("rab.after", 2'b00, 1, 1, 0, 0);
        checkRdv("rab.after", 0, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 32'hBEEF0004);
        checkRdv("rab.late", 0, 0);
        checkOutput("rab.late.grant", 32'(grant), 32'h0);

        // Unanswered M0 read: watchdog behaviour depends on the build
        m0Address = 32'h700; m0BurstCount = 7'd1;
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
        checkCtl("to.cmd", 2'b01, 0, 1, 1, 0);
`ifdef AVMM_ARB_TIMEOUT_EN
        for (int i = 0; i < 254; i++) begin
            nextCycle();
            applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
        end
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
        checkCtl("to.last", 2'b01, 1, 1, 0, 0);
        checkOutput("to.last.err", 32'(timeoutErr), 32'h0);
        nextCycle();
        applyStimulus(0, 0, 1, 0, 0, 0, 32'h0);
        checkCtl("to.fired", 2'b00, 1, 1, 0, 0);
        checkOutput("to.fired.err", 32'(timeoutErr), 32'h1);
        nextCycle();
        applyStimulus(0, 0, 1, 0, 0, 0, 32'h0);
        checkCtl("to.regrant", 2'b10, 1, 0, 1, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h33333333);
        checkRdv("to.regrant", 0, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
        checkCtl("to.end", 2'b00, 1, 1, 0, 0);
        checkOutput("to.end.err", 32'(timeoutErr), 32'h1);
`else
        for (int i = 0; i < 300; i++) begin
            nextCycle();
            applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
        end
        checkCtl("to.wait", 2'b01, 1, 1, 0, 0);
        checkOutput("to.wait.err", 32'(timeoutErr), 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h33333333);
        checkRdv("to.resp", 1, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
        checkCtl("to.end", 2'b00, 1, 1, 0, 0);
        checkOutput("to.end.err", 32'(timeoutErr), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule

// File: doc/avmm_bar_arbiter.md
AVMM_BAR_ARBITER -- requirements
Module: avmm_bar_arbiter

Interface
REQ-001 Parameter FIXED_PRIORITY, default 0; 0 = round-robin, 1 = M0 always wins ties.
REQ-002 Clk  in  1  single clock; all logic on its rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 M0Address, M1Address  in  32  byte address from master 0 (PCIe BAR0 path) and master 1 (local).
REQ-005 M0Read/M0Write, M1Read/M1Write  in  1 each  per-master read and write requests.
REQ-006 M0WriteData, M1WriteData  in  32  write data.
REQ-007 M0ByteEnable, M1ByteEnable  in  4  byte enables.
REQ-008 M0BurstCount, M1BurstCount  in  7  burst length in beats.
REQ-009 M0WaitRequest, M1WaitRequest  out  1  per-master stall.
REQ-010 M0ReadDataValid, M1ReadDataValid  out  1  per-master read beat valid.
REQ-011 M0ReadData, M1ReadData  out  32  read data; both driven from SReadData.
REQ-012 SAddress 32, SRead 1, SWrite 1, SWriteData 32, SByteEnable 4, SBurstCount 7  out  shared slave command.
REQ-013 SWaitRequest 1, SReadDataValid 1, SReadData 32  in  shared slave response.
REQ-014 Grant  out  2  one-hot current owner (bit0 = M0, bit1 = M1); 00 when idle.
REQ-015 TimeoutErr  out  1  sticky read-timeout flag.

Function
REQ-016 FSM states: IDLE, WRITE, READ_CMD, READ_DATA.
REQ-017 A master requests when its Read or Write is 1; if both are 1, the request is a write.
REQ-018 In IDLE: Grant=00, both MxWaitRequest=1, SRead=SWrite=0.
REQ-019 In IDLE the arbiter picks a winner; Grant is registered, so the winner's command appears on the slave one cycle after it is first sampled.
REQ-020 Round-robin: on a tie, the master not granted last wins; FIXED_PRIORITY=1 makes M0 win every tie.
REQ-021 On a grant, BurstCount is latched (0 treated as 1) and the FSM enters WRITE or READ_CMD.
REQ-022 While granted, the S* command outputs mux the owner's inputs combinationally, the owner's WaitRequest = SWaitRequest, and the other master's WaitRequest = 1.
REQ-023 WRITE: a beat counts when SWrite=1 and SWaitRequest=0; on the beat that reaches the latched count, the FSM returns to IDLE in the next cycle.
REQ-024 READ_CMD: on SRead=1 and SWaitRequest=0, go to READ_DATA; SRead=0 and owner WaitRequest=1 in READ_DATA.
REQ-025 READ_DATA: each SReadDataValid is routed to the owner's ReadDataValid only; on the last beat, go to IDLE.
REQ-026 The non-owner's ReadDataValid is always 0; SReadDataValid seen outside READ_DATA is dropped.
REQ-027 The beat counter is 7 bits and counts to at most 127; the owner cannot change mid-burst.
REQ-028 Back-to-back: returning to IDLE costs one cycle, then re-arbitration happens with the updated last-grant.

Reset
REQ-029 Reset forces IDLE, clears counters and latched count, sets last-grant = M1, Grant=00, SRead=SWrite=0, MxWaitRequest=1, MxReadDataValid=0, TimeoutErr=0.
REQ-030 Reset mid-burst aborts immediately; read beats still in flight after reset are discarded.

Configuration
REQ-031 Macro AVMM_ARB_TIMEOUT_EN defined: an 8-bit counter runs in READ_DATA, clears on each SReadDataValid, and on reaching 255 forces IDLE and sets TimeoutErr=1 until Reset.
REQ-032 Macro AVMM_ARB_TIMEOUT_EN undefined: no counter is built, TimeoutErr is tied 0, and READ_DATA waits indefinitely.

Verification
REQ-033 M0 write burst 4 @0x100, SWaitRequest=0 -> SWrite high 4 cycles from cycle+1, Grant=01, back to IDLE, M1WaitRequest=1 throughout.
REQ-034 M0 and M1 read same cycle, BurstCount=1, last-grant=M1 -> M0 served first, then M1; Grant sequence 01,00,10.
REQ-035 M1 read burst 3, slave returns 0xA5A5A5A5, 0x1, 0x2 with gaps -> M1ReadDataValid pulses 3 times with that data, M0ReadDataValid=0.
REQ-036 SWaitRequest held 5 cycles during an M0 write -> M0WaitRequest high 5 cycles, beat counter unchanged.
REQ-037 Reset asserted during READ_DATA after 1 of 4 beats -> IDLE next cycle, late beats produce no MxReadDataValid.
REQ-038 With AVMM_ARB_TIMEOUT_EN, a read with no response -> TimeoutErr=1 after 255 cycles in READ_DATA, FSM IDLE, then a new request is granted.
